vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 42 ++++
 rtl/vend_timer.sv | 44 ++++
 rtl/vend_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_vend_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vend_pkg
// Purpose  : Shared types and constants for the vending controller: FSM state
//            encoding, coin_code encoding, coin value lookup and default
//            product prices.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_1       = 2'd0;
    localparam logic [1:0] COIN_2       = 2'd1;
    localparam logic [1:0] COIN_5       = 2'd2;
    localparam logic [1:0] COIN_INVALID = 2'd3;

    localparam int DEFAULT_PRICE_A = 2;
    localparam int DEFAULT_PRICE_B = 3;

    localparam logic [4:0] MAX_TOTAL = 5'd15;

    // Face value of a coin in credit units; the invalid code is worth nothing.
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] value;
        case (code)
            COIN_1:  value = 4'd1;
            COIN_2:  value = 4'd2;
            COIN_5:  value = 4'd5;
            default: value = 4'd0;
        endcase
        return value;
    endfunction

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_timer.sv
`default_nettype none
// ============================================================================
// Module   : vend_timer
// Purpose  : Idle timer for the credit timeout. Counts cycles while run is
//            high, returns to zero on clear, and flags expired during the
//            TIMEOUT_CYCLES-th consecutive run cycle.
// Ports    : clk     - rising-edge clock
//            reset   - asynchronous active-high reset
//            clear   - synchronous count clear (has priority over run)
//            run     - count this cycle as idle
//            expired - terminal count reached in this cycle (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module vend_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LAST_CNT)) begin
            count <= count + 1'b1;
        end
    end

    // The count value equals the number of idle cycles already seen, so the
    // cycle in which it reaches LAST_CNT is the TIMEOUT_CYCLES-th idle cycle.
    assign expired = run && !clear && (count == LAST_CNT);

endmodule : vend_timer
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_ctrl
// Purpose  : Coin-operated vending controller. Accumulates credit, vends
//            product A or B, returns change through a req/ack dispenser
//            handshake and handles customer refunds.
// Config   : define VEND_TIMEOUT_EN to enable an automatic refund after
//            TIMEOUT_CYCLES idle cycles in CREDIT (instantiates vend_timer).
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            coin_valid/coin_code - coin strobe and denomination
//            sel_a/sel_b          - product select requests
//            refund_req           - customer cancel
//            change_ack           - dispenser has paid change_amt
//            total                - current credit
//            vend_a/vend_b        - one-cycle dispense strobes
//            change_req/change_amt- dispenser request and amount
//            coin_reject, deny    - one-cycle status pulses
//            busy                 - high in VEND and CHANGE
// Revision : 1.0 - initial release
// ============================================================================
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_A        = DEFAULT_PRICE_A,
    parameter int PRICE_B        = DEFAULT_PRICE_B,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       sel_a,
    input  logic       sel_b,
    input  logic       refund_req,
    input  logic       change_ack,
    output logic [3:0] total,
    output logic       vend_a,
    output logic       vend_b,
    output logic       change_req,
    output logic [3:0] change_amt,
    output logic       coin_reject,
    output logic       deny,
    output logic       busy
);

    localparam logic [3:0] PRICE_A_U = 4'(PRICE_A);
    localparam logic [3:0] PRICE_B_U = 4'(PRICE_B);

    state_t     state,       state_nxt;
    logic       vend_phase,  vend_phase_nxt;   // 0: strobe pending, 1: strobe out
    logic       vend_is_b,   vend_is_b_nxt;
    logic [3:0] total_nxt;
    logic       change_req_nxt;
    logic [3:0] change_amt_nxt;
    logic       vend_a_nxt, vend_b_nxt;
    logic       coin_reject_nxt, deny_nxt;

    logic [4:0] coin_sum;
    logic       coin_fits;
    logic [3:0] sel_price;
    logic [3:0] vend_price;
    logic [3:0] remainder;
    logic [3:0] total_post;
    logic       timeout;
    logic       activity;

    assign coin_sum   = {1'b0, total} + {1'b0, coin_value(coin_code)};
    assign coin_fits  = (coin_code != COIN_INVALID) && (coin_sum <= MAX_TOTAL);
    // A has fixed priority over B when both selects are high.
    assign sel_price  = sel_a ? PRICE_A_U : PRICE_B_U;
    assign vend_price = vend_is_b ? PRICE_B_U : PRICE_A_U;
    assign remainder  = total - vend_price;
    assign activity   = coin_valid || sel_a || sel_b || refund_req;

`ifdef VEND_TIMEOUT_EN
    logic timer_run;

    assign timer_run = (state == ST_CREDIT) && !activity;

    vend_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!timer_run),
        .run     (timer_run),
        .expired (timeout)
    );
`else
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            vend_phase  <= 1'b0;
            vend_is_b   <= 1'b0;
            total       <= 4'd0;
            change_req  <= 1'b0;
            change_amt  <= 4'd0;
            vend_a      <= 1'b0;
            vend_b      <= 1'b0;
            coin_reject <= 1'b0;
            deny        <= 1'b0;
        end else begin
            state       <= state_nxt;
            vend_phase  <= vend_phase_nxt;
            vend_is_b   <= vend_is_b_nxt;
            total       <= total_nxt;
            change_req  <= change_req_nxt;
            change_amt  <= change_amt_nxt;
            vend_a      <= vend_a_nxt;
            vend_b      <= vend_b_nxt;
            coin_reject <= coin_reject_nxt;
            deny        <= deny_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        vend_phase_nxt  = vend_phase;
        vend_is_b_nxt   = vend_is_b;
        total_nxt       = total;
        change_req_nxt  = change_req;
        change_amt_nxt  = change_amt;
        vend_a_nxt      = 1'b0;
        vend_b_nxt      = 1'b0;
        coin_reject_nxt = 1'b0;
        deny_nxt        = 1'b0;
        total_post      = total;

        case (state)
            ST_IDLE, ST_CREDIT: begin
                if (coin_valid) begin
                    if (coin_fits) begin
                        total_post = coin_sum[3:0];
                    end else begin
                        coin_reject_nxt = 1'b1;
                    end
                end
                total_nxt = total_post;
                state_nxt = (total_post == 4'd0) ? ST_IDLE : ST_CREDIT;

                // The select is judged on the credit held before any coin
                // arriving in the same cycle; the coin is still banked.
                if (sel_a || sel_b) begin
                    if ((state == ST_CREDIT) && (total >= sel_price)) begin
                        state_nxt      = ST_VEND;
                        vend_phase_nxt = 1'b0;
                        vend_is_b_nxt  = !sel_a;
                    end else begin
                        deny_nxt = 1'b1;
                    end
                end else if ((state == ST_CREDIT) && (refund_req || timeout)) begin
                    state_nxt      = ST_CHANGE;
                    change_req_nxt = 1'b1;
                    change_amt_nxt = total_post;
                end
            end

            ST_VEND: begin
                coin_reject_nxt = coin_valid;
                if (!vend_phase) begin
                    vend_phase_nxt = 1'b1;
                    vend_a_nxt     = !vend_is_b;
                    vend_b_nxt     = vend_is_b;
                end else begin
                    // Credit is debited as the strobe cycle ends.
                    total_nxt = remainder;
                    if (remainder == 4'd0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt      = ST_CHANGE;
                        change_req_nxt = 1'b1;
                        change_amt_nxt = remainder;
                    end
                end
            end

            ST_CHANGE: begin
                coin_reject_nxt = coin_valid;
                if (change_ack) begin
                    state_nxt      = ST_IDLE;
                    total_nxt      = 4'd0;
                    change_req_nxt = 1'b0;
                    change_amt_nxt = 4'd0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state == ST_VEND) || (state == ST_CHANGE);

endmodule : vend_ctrl
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_ctrl
// Purpose  : Self-checking bench for vend_ctrl: directed vector table,
//            hand-written reset/timeout sequences and random stimulus against
//            a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl;

    localparam int PA = 2;
    localparam int PB = 3;
    localparam int TO = 8;
`ifdef VEND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       sel_a, sel_b, refund_req, change_ack;
    logic [3:0] total, change_amt;
    logic       vend_a, vend_b, change_req, coin_reject, deny, busy;

    int checks = 0;
    int errors = 0;

    vend_ctrl #(
        .PRICE_A        (PA),
        .PRICE_B        (PB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_valid  (coin_valid),
        .coin_code   (coin_code),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .refund_req  (refund_req),
        .change_ack  (change_ack),
        .total       (total),
        .vend_a      (vend_a),
        .vend_b      (vend_b),
        .change_req  (change_req),
        .change_amt  (change_amt),
        .coin_reject (coin_reject),
        .deny        (deny),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_credit;
    bit m_change;
    int m_vend_cd;    // 2: vend accepted, 1: strobe cycle, 0: no vend
    int m_price;
    bit m_is_b;
    int m_amt;
    bit m_rej, m_deny, m_va, m_vb;
    int m_idle;

    function automatic int coin_worth(input int code);
        if (code == 0) return 1;
        if (code == 1) return 2;
        if (code == 2) return 5;
        return 0;
    endfunction

    task automatic model_reset();
        m_credit = 0; m_change = 0; m_vend_cd = 0; m_price = 0; m_is_b = 0;
        m_amt = 0; m_rej = 0; m_deny = 0; m_va = 0; m_vb = 0; m_idle = 0;
    endtask

    task automatic model_step();
        int pre;
        bit act;
        bit tmo;
        m_rej = 0; m_deny = 0; m_va = 0; m_vb = 0;
        if (m_vend_cd > 0 || m_change) begin
            m_idle = 0;
            if (coin_valid) m_rej = 1;
            if (m_vend_cd == 2) begin
                m_vend_cd = 1;
                if (m_is_b) m_vb = 1; else m_va = 1;
            end else if (m_vend_cd == 1) begin
                m_vend_cd = 0;
                m_credit  = m_credit - m_price;
                if (m_credit > 0) begin
                    m_change = 1;
                    m_amt    = m_credit;
                end
            end else if (change_ack) begin
                m_credit = 0; m_change = 0; m_amt = 0;
            end
        end else begin
            pre = m_credit;
            act = coin_valid | sel_a | sel_b | refund_req;
            if (coin_valid) begin
                if (coin_code != 2'd3 && m_credit + coin_worth(int'(coin_code)) <= 15)
                    m_credit = m_credit + coin_worth(int'(coin_code));
                else
                    m_rej = 1;
            end
            if (pre > 0 && !act) m_idle++; else m_idle = 0;
            tmo = TO_EN && pre > 0 && m_idle >= TO;
            if (sel_a || sel_b) begin
                if (pre > 0 && pre >= (sel_a ? PA : PB)) begin
                    m_vend_cd = 2;
                    m_price   = sel_a ? PA : PB;
                    m_is_b    = !sel_a;
                end else begin
                    m_deny = 1;
                end
            end else if (pre > 0 && (refund_req || tmo)) begin
                m_change = 1;
                m_amt    = m_credit;
                m_idle   = 0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_total"},  int'(total),       m_credit);
        check({tag, "_vend_a"}, int'(vend_a),      int'(m_va));
        check({tag, "_vend_b"}, int'(vend_b),      int'(m_vb));
        check({tag, "_creq"},   int'(change_req),  int'(m_change));
        check({tag, "_camt"},   int'(change_amt),  m_amt);
        check({tag, "_reject"}, int'(coin_reject), int'(m_rej));
        check({tag, "_deny"},   int'(deny),        int'(m_deny));
        check({tag, "_busy"},   int'(busy),        int'(m_vend_cd > 0 || m_change));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_total"},  int'(total),       0);
        check({tag, "_vend"},   int'(vend_a | vend_b), 0);
        check({tag, "_creq"},   int'(change_req),  0);
        check({tag, "_camt"},   int'(change_amt),  0);
        check({tag, "_pulses"}, int'(coin_reject | deny), 0);
        check({tag, "_busy"},   int'(busy),        0);
    endtask

    task automatic drive(input bit cv, input int code, input bit sa, input bit sb,
                         input bit rf, input bit ak);
        coin_valid = cv; coin_code = 2'(code); sel_a = sa; sel_b = sb;
        refund_req = rf; change_ack = ak;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asserted 1 time unit after an edge; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_zero(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit cv; int code; bit sa; bit sb; bit rf; bit ak;
        int tot; bit va; bit vb; bit cr; int amt; bit rj; bit dn; bit by;
    } vec_t;

    localparam int NVEC = 35;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input bit cv, input int code, input bit sa, input bit sb,
                                input bit rf, input bit ak, input int tot, input bit va,
                                input bit vb, input bit cr, input int amt, input bit rj,
                                input bit dn, input bit by);
        vec_t v;
        v.cv = cv; v.code = code; v.sa = sa; v.sb = sb; v.rf = rf; v.ak = ak;
        v.tot = tot; v.va = va; v.vb = vb; v.cr = cr; v.amt = amt;
        v.rj = rj; v.dn = dn; v.by = by;
        return v;
    endfunction

    initial begin
        //            cv code sa sb rf ak | tot va vb cr amt rj dn by
        // coins 2,1 then A: vend, change 1, ack
        tbl[0]  = mk(1, 1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
        // coin 2, B denied, then refund
        tbl[7]  = mk(1, 1, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 0, 0,   2, 0, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 0,   2, 0, 0, 1, 2, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
        // 5,5,5 then overflowing coin; coin in VEND rejected
        tbl[12] = mk(1, 2, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 2, 0, 0, 0, 0,  10, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 2, 0, 0, 0, 0,  15, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0, 1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0,  15, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 1, 0, 0, 0,  15, 0, 0, 0, 0, 1, 0, 1);
        tbl[18] = mk(1, 0, 0, 0, 0, 0,  15, 1, 0, 0, 0, 1, 0, 1);
        tbl[19] = mk(0, 0, 0, 0, 0, 0,  13, 0, 0, 1, 13, 0, 0, 1);
        tbl[20] = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
        // coin 5, A and B together: A wins, change 3
        tbl[21] = mk(1, 2, 0, 0, 0, 0,   5, 0, 0, 0, 0, 0, 0, 0);
        tbl[22] = mk(0, 0, 1, 1, 0, 0,   5, 0, 0, 0, 0, 0, 0, 1);
        tbl[23] = mk(0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0, 0, 0, 1);
        tbl[24] = mk(0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 3, 0, 0, 1);
        tbl[25] = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);
        // invalid coin and select in IDLE
        tbl[26] = mk(1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0);
        tbl[27] = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        // coin with select judged on pre-coin credit, then exact B vend
        tbl[28] = mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
        tbl[29] = mk(1, 1, 0, 1, 0, 0,   3, 0, 0, 0, 0, 0, 1, 0);
        tbl[30] = mk(0, 0, 0, 1, 0, 0,   3, 0, 0, 0, 0, 0, 0, 1);
        tbl[31] = mk(0, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0, 0, 1);
        tbl[32] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        // refund and ack ignored in IDLE
        tbl[33] = mk(0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0);
        tbl[34] = mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        do_reset("reset");

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].cv, tbl[i].code, tbl[i].sa, tbl[i].sb, tbl[i].rf, tbl[i].ak);
            step();
            check($sformatf("vec%0d_total", i),  int'(total),       tbl[i].tot);
            check($sformatf("vec%0d_vend_a", i), int'(vend_a),      int'(tbl[i].va));
            check($sformatf("vec%0d_vend_b", i), int'(vend_b),      int'(tbl[i].vb));
            check($sformatf("vec%0d_creq", i),   int'(change_req),  int'(tbl[i].cr));
            check($sformatf("vec%0d_camt", i),   int'(change_amt),  tbl[i].amt);
            check($sformatf("vec%0d_reject", i), int'(coin_reject), int'(tbl[i].rj));
            check($sformatf("vec%0d_deny", i),   int'(deny),        int'(tbl[i].dn));
            check($sformatf("vec%0d_busy", i),   int'(busy),        int'(tbl[i].by));
        end

        // Coin 5, refund, then reset mid-CHANGE before any ack.
        do_reset("pre_refund");
        drive(1, 2, 0, 0, 0, 0);
        step();
        check("refund_coin_total", int'(total), 5);
        drive(0, 0, 0, 0, 1, 0);
        step();
        check("refund_creq", int'(change_req), 1);
        check("refund_camt", int'(change_amt), 5);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("refund_hold_creq", int'(change_req), 1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("refund_async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step();
        check_zero("refund_after_reset");

        // Reset in the middle of a vend abandons it.
        drive(1, 2, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 0, 0);
        step();
        check("midvend_busy", int'(busy), 1);
        do_reset("midvend_reset");

`ifdef VEND_TIMEOUT_EN
        // Coin 2 then TO idle cycles: automatic refund of 2.
        drive(1, 1, 0, 0, 0, 0);
        step();
        check("tmo_total", int'(total), 2);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k < TO; k++) begin
            step();
            check($sformatf("tmo_wait%0d_creq", k), int'(change_req), 0);
        end
        step();
        check("tmo_creq", int'(change_req), 1);
        check("tmo_camt", int'(change_amt), 2);
        do_reset("tmo_reset");
`endif

        // Random stimulus against the reference model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rand_reset");
            end
            drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            step();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vend_ctrl
`default_nettype wire
